reset_seq: RTL and testbench



---
 rtl/reset_seq.sv | 147 ++++++++++++++
 tb/tb_reset_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_seq.sv
// Reset sequencer: synchronises button and PLL lock, debounces button release,
// then releases CHANNELS active-high resets one by one, STRETCH cycles apart.
module reset_seq #(
    parameter int CHANNELS = 3,
    parameter int STRETCH  = 8,
    parameter int DEBOUNCE = 16
) (
    input  logic                I_clk,
    input  logic                I_rst_n,
    input  logic                I_rst_btn,
    input  logic                I_pll_lock,
    output logic [CHANNELS-1:0] O_rst,
    output logic                O_ready
);

    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int CNT_W = $clog2(STRETCH + 1);
    localparam int STG_W = $clog2(CHANNELS + 1);

    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    logic             r_btn_meta;
    logic             r_btn_s;
    logic             r_lock_meta;
    logic             r_lock_s;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_btn_ok;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [STG_W-1:0] r_stage;
    logic             w_abort;

    assign w_abort = !r_btn_s || !r_lock_s;

    // Two-flop synchronisers for the asynchronous button and lock pins
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_btn_meta  <= 1'b0;
            r_btn_s     <= 1'b0;
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_btn_meta  <= I_rst_btn;
            r_btn_s     <= r_btn_meta;
            r_lock_meta <= I_pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Release debounce: saturating run-length of high samples, press clears at once
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_db_cnt <= '0;
            r_btn_ok <= 1'b0;
        end else if (!r_btn_s) begin
            r_db_cnt <= '0;
            r_btn_ok <= 1'b0;
        end else begin
            if (r_db_cnt != DB_MAX) begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end else begin
                r_db_cnt <= r_db_cnt;
            end
            r_btn_ok <= (r_db_cnt == DB_LAST) || (r_db_cnt == DB_MAX);
        end
    end

    // Sequencer FSM; outputs are registered here, abort wins over any release
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_stage <= '0;
            O_rst   <= '1;
            O_ready <= 1'b0;
        end else if ((r_state != ST_HOLD) && w_abort) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_stage <= '0;
            O_rst   <= '1;
            O_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    r_cnt   <= '0;
                    r_stage <= '0;
                    O_rst   <= '1;
                    O_ready <= 1'b0;
                    if (r_btn_ok) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_WAIT: begin
                    O_rst   <= '1;
                    O_ready <= 1'b0;
                    r_stage <= '0;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == CNT_LAST) begin
                        // Channels release low-index first, so a left shift keeps them monotonic
                        O_rst   <= O_rst << 1;
                        r_cnt   <= '0;
                        r_stage <= r_stage + STG_W'(1);
                        if (r_stage == STG_LAST) begin
                            r_state <= ST_RUN;
                            O_ready <= 1'b1;
                        end else begin
                            O_ready <= 1'b0;
                        end
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    O_rst   <= '0;
                    O_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_HOLD;
                    r_cnt   <= '0;
                    r_stage <= '0;
                    O_rst   <= '1;
                    O_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: three parameter sets driven by shared pins, checked against
// a schedule model built from edge counts and the release-time formula.
module tb_reset_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        btn;
    logic        lock;
    logic [2:0]  o_rst_a;
    logic        o_ready_a;
    logic [0:0]  o_rst_b;
    logic        o_ready_b;
    logic [15:0] o_rst_c;
    logic        o_ready_c;

    reset_seq #(.CHANNELS(3), .STRETCH(8), .DEBOUNCE(4)) u_a (
        .I_clk(clk), .I_rst_n(rst_n), .I_rst_btn(btn), .I_pll_lock(lock),
        .O_rst(o_rst_a), .O_ready(o_ready_a));
    reset_seq #(.CHANNELS(1), .STRETCH(1), .DEBOUNCE(1)) u_b (
        .I_clk(clk), .I_rst_n(rst_n), .I_rst_btn(btn), .I_pll_lock(lock),
        .O_rst(o_rst_b), .O_ready(o_ready_b));
    reset_seq #(.CHANNELS(16), .STRETCH(3), .DEBOUNCE(16)) u_c (
        .I_clk(clk), .I_rst_n(rst_n), .I_rst_btn(btn), .I_pll_lock(lock),
        .O_rst(o_rst_c), .O_ready(o_ready_c));

    int nch[3]     = '{3, 1, 16};
    int stretch[3] = '{8, 1, 3};
    int deb[3]     = '{4, 1, 16};

    // Model: t = edges since the sequence left HOLD (-1 while held), run = high-sample run
    int t[3];
    int run[3];
    bit ok[3];
    bit hb0, hb1, hl0, hl1;
    int edge_n;
    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            t[i] = -1;
            run[i] = 0;
            ok[i] = 1'b0;
        end
        hb0 = 1'b0; hb1 = 1'b0; hl0 = 1'b0; hl1 = 1'b0;
        edge_n = 0;
    endtask

    task automatic model_step();
        bit bs, ls;
        bs = hb1;
        ls = hl1;
        for (int i = 0; i < 3; i++) begin
            if (t[i] >= 0) begin
                if (!bs || !ls) t[i] = -1;
                else if (t[i] < 1000000) t[i] = t[i] + 1;
            end else if (ok[i]) begin
                t[i] = 0;
            end
            if (bs) begin
                if (run[i] < 1000000) run[i] = run[i] + 1;
            end else begin
                run[i] = 0;
            end
            ok[i] = (run[i] >= deb[i]);
        end
        hb1 = hb0; hb0 = btn;
        hl1 = hl0; hl0 = lock;
        edge_n = edge_n + 1;
    endtask

    function automatic int released(int i);
        int r;
        r = (t[i] < 0) ? 0 : (t[i] / stretch[i]) - 1;
        if (r < 0) r = 0;
        if (r > nch[i]) r = nch[i];
        return r;
    endfunction

    function automatic logic [16:0] full_mask(int i);
        return (17'd1 << nch[i]) - 17'd1;
    endfunction

    function automatic logic [15:0] exp_rst(int i);
        logic [16:0] low;
        low = (17'd1 << released(i)) - 17'd1;
        return 16'(full_mask(i) & ~low);
    endfunction

    function automatic logic [15:0] obs_rst(int i);
        case (i)
            0:       return {13'd0, o_rst_a};
            1:       return {15'd0, o_rst_b};
            default: return o_rst_c;
        endcase
    endfunction

    function automatic logic obs_ready(int i);
        case (i)
            0:       return o_ready_a;
            1:       return o_ready_b;
            default: return o_ready_c;
        endcase
    endfunction

    task automatic check_all();
        logic [16:0] m;
        for (int i = 0; i < 3; i++) begin
            checks++;
            assert (obs_rst(i) === exp_rst(i)) else begin
                errors++;
                $error("FAIL rst[%0d] edge=%0d obs=%h exp=%h", i, edge_n, obs_rst(i), exp_rst(i));
            end
            checks++;
            assert (obs_ready(i) === (released(i) == nch[i])) else begin
                errors++;
                $error("FAIL ready[%0d] edge=%0d obs=%b exp=%b", i, edge_n, obs_ready(i), released(i) == nch[i]);
            end
            m = full_mask(i) & ~{1'b0, obs_rst(i)};
            checks++;
            assert ((m & (m + 17'd1)) === 17'd0) else begin
                errors++;
                $error("FAIL monotonic[%0d] edge=%0d obs=%h", i, edge_n, obs_rst(i));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic nominal_run();
        logic [2:0] e;
        for (int n = 0; n < 45; n++) begin
            tick();
            e = (edge_n < 23) ? 3'b111 : (edge_n < 31) ? 3'b110 : (edge_n < 39) ? 3'b100 : 3'b000;
            checks++;
            assert (o_rst_a === e && o_ready_a === (edge_n >= 39)) else begin
                errors++;
                $error("FAIL nominal E%0d obs=%b/%b exp=%b/%b", edge_n, o_rst_a, o_ready_a, e, edge_n >= 39);
            end
        end
    endtask

    task automatic check_a(string tag, logic [2:0] e_rst, logic e_rdy);
        checks++;
        assert (o_rst_a === e_rst && o_ready_a === e_rdy) else begin
            errors++;
            $error("FAIL %s obs=%b/%b exp=%b/%b", tag, o_rst_a, o_ready_a, e_rst, e_rdy);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        btn   = 1'b1;
        lock  = 1'b1;
        model_reset();
        #12;
        checks++;
        assert (o_rst_a === 3'b111 && o_rst_b === 1'b1 && o_rst_c === 16'hFFFF &&
                !o_ready_a && !o_ready_b && !o_ready_c) else begin
            errors++;
            $error("FAIL reset_state obs=%b/%b/%h exp=111/1/ffff", o_rst_a, o_rst_b, o_rst_c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nominal_run();

        // Button bounce from RUN: single low, five 2/2 toggles, then steady high
        btn = 1'b0;
        tick();
        btn = 1'b1;
        tick();
        check_a("bounce_pre_abort", 3'b000, 1'b1);
        tick();
        check_a("bounce_abort", 3'b111, 1'b0);
        for (int k = 0; k < 5; k++) begin
            btn = 1'b0; tick(); tick();
            btn = 1'b1; tick(); tick();
        end
        for (int k = 0; k < 80; k++) tick();

        // Lock loss while channel 0 is released
        btn = 1'b0; tick(); btn = 1'b1;
        n = 0;
        while (o_rst_a !== 3'b110 && n < 300) begin tick(); n++; end
        check_a("reach_110", 3'b110, 1'b0);
        lock = 1'b0;
        tick(); tick();
        check_a("lock_pre_abort", 3'b110, 1'b0);
        tick();
        check_a("lock_abort", 3'b111, 1'b0);
        for (int k = 0; k < 6; k++) tick();
        lock = 1'b1;
        for (int k = 0; k < 80; k++) tick();

        // Late lock after reset release
        #1 rst_n = 1'b0; lock = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 50; k++) tick();
        check_a("late_lock_hold", 3'b111, 1'b0);
        lock = 1'b1;
        for (int k = 0; k < 80; k++) tick();

        // Asynchronous reset pulse between edges while in RUN
        n = 0;
        while (o_ready_a !== 1'b1 && n < 300) begin tick(); n++; end
        check_a("reach_run", 3'b000, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        assert (o_rst_a === 3'b111 && !o_ready_a && o_rst_c === 16'hFFFF && o_rst_b === 1'b1) else begin
            errors++;
            $error("FAIL async_reset obs=%b/%b/%h exp=111/0/ffff", o_rst_a, o_ready_a, o_rst_c);
        end
        model_reset();
        #2 rst_n = 1'b1;
        nominal_run();

        // Random glitches on button and lock against the schedule model
        for (int k = 0; k < 3000; k++) begin
            btn  = ($urandom_range(0, 99) != 0);
            lock = ($urandom_range(0, 149) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
